// File: rtl/map_lut.sv
// Tile-map wall lookup for the maze: combinational "is (x,y) a wall?" plus a writable overlay.
// Optional MAP_WRITE_PROTECT_EN: when defined, writes to boundary tiles are ignored.
module map_lut #(
    parameter int unsigned MAP_W      = 27,
    parameter int unsigned MAP_H      = 24,
    parameter int unsigned TUNNEL_ROW = 11,
    parameter int unsigned TUNNEL_COL = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] x,
    input  logic [6:0] y,
    output logic       q,
    input  logic       wr_en,
    input  logic [7:0] wr_x,
    input  logic [6:0] wr_y,
    input  logic       wr_data
);

    localparam int unsigned Tiles = MAP_W * MAP_H;
    localparam int unsigned IdxW  = $clog2(Tiles);

    function automatic logic [Tiles-1:0] build_default_map();
        logic [Tiles-1:0] m;
        logic             on_border;
        logic             tunnel;
        logic             pillar;
        m = '0;
        for (int unsigned ty = 0; ty < MAP_H; ty++) begin
            for (int unsigned tx = 0; tx < MAP_W; tx++) begin
                on_border = (tx == 0) || (tx == MAP_W - 1) || (ty == 0) || (ty == MAP_H - 1);
                tunnel    = ((ty == TUNNEL_ROW) && ((tx == 0) || (tx == MAP_W - 1))) ||
                            ((tx == TUNNEL_COL) && ((ty == 0) || (ty == MAP_H - 1)));
                // Pillars stop one row short of the bottom corridor on the y axis.
                pillar    = (tx % 2 == 0) && (tx >= 2) && (tx <= MAP_W - 3) &&
                            (ty % 2 == 0) && (ty >= 2) && (ty <= MAP_H - 4);
                m[ty * MAP_W + tx] = (on_border && !tunnel) || pillar;
            end
        end
        return m;
    endfunction

    localparam logic [Tiles-1:0] DefaultMap = build_default_map();

    logic [Tiles-1:0] tiles_q;
    logic [Tiles-1:0] tiles_d;

    logic [31:0]     rd_x;
    logic [31:0]     rd_y;
    logic [31:0]     wx;
    logic [31:0]     wy;
    logic            rd_hit;
    logic            wr_hit;
    logic            wr_allow;
    logic [IdxW-1:0] rd_idx;
    logic [IdxW-1:0] wr_idx;

    assign rd_x   = 32'(x);
    assign rd_y   = 32'(y);
    assign wx     = 32'(wr_x);
    assign wy     = 32'(wr_y);

    // Out-of-range coordinates (including 255/127 underflow) read as walls.
    assign rd_hit = (rd_x < MAP_W) && (rd_y < MAP_H);
    assign rd_idx = IdxW'(rd_y * MAP_W + rd_x);
    assign q      = rd_hit ? tiles_q[rd_idx] : 1'b1;

    assign wr_hit = (wx < MAP_W) && (wy < MAP_H);
    assign wr_idx = IdxW'(wy * MAP_W + wx);

`ifdef MAP_WRITE_PROTECT_EN
    assign wr_allow = !((wx == 0) || (wx == MAP_W - 1) || (wy == 0) || (wy == MAP_H - 1));
`else
    assign wr_allow = 1'b1;
`endif

    always_comb begin
        tiles_d = tiles_q;
        if (wr_en && wr_hit && wr_allow) begin
            tiles_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tiles_q <= DefaultMap;
        end else begin
            tiles_q <= tiles_d;
        end
    end

endmodule

// File: tb/tb_map_lut.sv
// Scoreboard bench for map_lut: randomized lookups/writes against a tile-array reference model.
module tb_map_lut;

    localparam int W = 27;
    localparam int H = 24;

    logic       clk;
    logic       reset;
    logic [7:0] x;
    logic [6:0] y;
    logic       q;
    logic       wr_en;
    logic [7:0] wr_x;
    logic [6:0] wr_y;
    logic       wr_data;

    map_lut dut (
        .clk     (clk),
        .reset   (reset),
        .x       (x),
        .y       (y),
        .q       (q),
        .wr_en   (wr_en),
        .wr_x    (wr_x),
        .wr_y    (wr_y),
        .wr_data (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic  exp;
    } exp_t;

    exp_t sb[$];
    event sample_ev;
    int   errors = 0;
    int   checks = 0;
    bit   ref_map[W][H];

    function automatic bit spec_default(int tx, int ty);
        bit border;
        border = (tx == 0 || tx == W - 1 || ty == 0 || ty == H - 1);
        if ((tx == 0 && ty == 11) || (tx == 26 && ty == 11) ||
            (tx == 13 && ty == 0) || (tx == 13 && ty == 23)) return 1'b0;
        if (border) return 1'b1;
        return (tx >= 2 && tx <= 24 && tx % 2 == 0 && ty >= 2 && ty <= 20 && ty % 2 == 0);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < W; i++)
            for (int j = 0; j < H; j++)
                ref_map[i][j] = spec_default(i, j);
    endfunction

    function automatic bit model_q(int tx, int ty);
        if (tx >= W || ty >= H) return 1'b1;
        return ref_map[tx][ty];
    endfunction

    function automatic bit model_writable(int tx, int ty);
        if (tx >= W || ty >= H) return 1'b0;
`ifdef MAP_WRITE_PROTECT_EN
        if (tx == 0 || tx == W - 1 || ty == 0 || ty == H - 1) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Monitor: every sample strobe pops one expectation and compares it with q.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: q=%0b with no expectation queued", q);
            end else begin
                e = sb.pop_front();
                if (q !== e.exp) begin
                    errors++;
                    $display("FAIL %s: q=%0b expected %0b", e.name, q, e.exp);
                end
            end
        end
    end

    task automatic lookup(input int tx, input int ty, input string name);
        exp_t e;
        x = 8'(tx);
        y = 7'(ty);
        e.name = $sformatf("%s(%0d,%0d)", name, tx, ty);
        e.exp  = model_q(tx, ty);
        sb.push_back(e);
        #1;
        -> sample_ev;
        #1;
    endtask

    // Drives one write; also checks that a same-tile lookup before the edge sees the old value.
    task automatic do_write(input int tx, input int ty, input bit d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_x    = 8'(tx);
        wr_y    = 7'(ty);
        wr_data = d;
        lookup(tx, ty, "pre_edge");
        @(posedge clk);
        if (!reset && model_writable(tx, ty)) ref_map[tx][ty] = d;
        #1;
        wr_en = 1'b0;
    endtask

    task automatic sweep(input string name, input bit check_default);
        int dut_walls;
        int ref_walls;
        dut_walls = 0;
        ref_walls = 0;
        for (int j = 0; j < H; j++) begin
            for (int i = 0; i < W; i++) begin
                lookup(i, j, name);
                dut_walls += int'(q);
                ref_walls += int'(ref_map[i][j]);
            end
        end
        checks++;
        if (dut_walls != (check_default ? 214 : ref_walls)) begin
            errors++;
            $display("FAIL %s_wall_count: counted %0d expected %0d", name, dut_walls,
                     check_default ? 214 : ref_walls);
        end
    endtask

    initial begin
        int tx;
        int ty;
        reset   = 1'b1;
        x       = '0;
        y       = '0;
        wr_en   = 1'b0;
        wr_x    = '0;
        wr_y    = '0;
        wr_data = 1'b0;
        model_reset();
        #2;
        lookup(0, 0, "during_reset");
        lookup(13, 0, "during_reset");
        @(negedge clk);
        reset = 1'b0;

        lookup(0, 0, "default");
        lookup(5, 0, "default");
        lookup(0, 11, "default");
        lookup(26, 11, "default");
        lookup(13, 0, "default");
        lookup(13, 23, "default");
        lookup(2, 2, "default");
        lookup(3, 3, "default");
        lookup(24, 20, "default");
        lookup(1, 1, "default");
        lookup(27, 5, "oob");
        lookup(255, 5, "oob");
        lookup(5, 24, "oob");
        lookup(5, 127, "oob");

        do_write(3, 3, 1'b1);
        lookup(3, 3, "after_write");
        lookup(2, 2, "neighbour");
        lookup(4, 4, "neighbour");
        do_write(2, 2, 1'b0);
        lookup(2, 2, "after_write");

        // Asynchronous reset between edges must restore the map before the next edge.
        @(negedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        lookup(2, 2, "async_reset");
        lookup(3, 3, "async_reset");
        @(negedge clk);
        reset = 1'b0;

        do_write(30, 5, 1'b0);
        reset = 1'b1;
        do_write(3, 3, 1'b1);
        do_write(1, 1, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        sweep("default_sweep", 1'b1);

        for (int n = 0; n < 150; n++) begin
            tx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(27, 255)) : int'($urandom_range(0, 26));
            ty = ($urandom_range(0, 9) == 0) ? int'($urandom_range(24, 127)) : int'($urandom_range(0, 23));
            do_write(tx, ty, 1'($urandom()));
            lookup(int'($urandom_range(0, 26)), int'($urandom_range(0, 23)), "rand");
            lookup(tx, ty, "rand_wr_tile");
        end
        sweep("rand_sweep", 1'b0);

        do_write(0, 5, 1'b0);
        lookup(0, 5, "border_write");

        for (int t = 0; t < 100 && sb.size() != 0; t++) #1;
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/map_lut.md
Name: map_lut

Overview:
- Tile-map lookup for the maze: answers "is tile (x,y) a wall?" combinationally, so the movement handler can block a move in the same cycle.
- The map is a 27 x 24 tile grid: x 0..26, y 0..23.
- Holds a writable overlay so game logic can open or close tiles at run time (e.g. a ghost-house door).
- Sits beside movement_handler, which feeds it the candidate next position.

Parameters:
- MAP_W, 27, number of columns; valid x is 0..MAP_W-1.
- MAP_H, 24, number of rows; valid y is 0..MAP_H-1.
- TUNNEL_ROW, 11, row whose x=0 and x=MAP_W-1 border tiles are open.
- TUNNEL_COL, 13, column whose y=0 and y=MAP_H-1 border tiles are open.

Ports:
- clk  input  1  clock; all writes occur on the rising edge.
- reset  input  1  asynchronous, active-high; restores the default map.
- x  input  8  lookup column.
- y  input  7  lookup row.
- q  output  1  1 = wall or out of range; 0 = passable.
- wr_en  input  1  write strobe.
- wr_x  input  8  write column.
- wr_y  input  7  write row.
- wr_data  input  1  tile value to store (1 = wall).

Behaviour:
- Storage: one bit per tile, MAP_W*MAP_H flops (648 at defaults).
- Default map, applied while reset is high, asynchronously:
  - Boundary tiles are walls: x=0, x=26, y=0 or y=23.
  - Exceptions, which are open: (0,11), (26,11), (13,0), (13,23).
  - Interior pillars are walls: x even in 2..24 and y even in 2..20.
  - All other tiles are open.
  - At defaults this gives 94 boundary walls + 120 pillars = 214 walls.
- Lookup:
  - q is purely combinational from x, y and the stored map; zero latency.
  - If x>=MAP_W or y>=MAP_H, q=1. This covers the underflow values 255 and 127 produced by decrementing 0.
- Write:
  - When wr_en=1 at a rising edge with wr_x<MAP_W and wr_y<MAP_H and reset low, tile(wr_x,wr_y) <= wr_data.
  - Out-of-range writes are ignored; no other tile changes.
  - A write is visible on q immediately after the edge.
  - A same-tile lookup in the write cycle returns the old value.
- Reset:
  - Reset mid-operation discards all writes and restores the default map immediately, without waiting for clk.
  - Writes are ignored while reset is high.
  - q is valid during reset and reflects the default map.
- No handshake: every write strobe is accepted in a single cycle.

Optional Feature:
- Macro: MAP_WRITE_PROTECT_EN.
- Defined: writes targeting any boundary tile (x=0, x=MAP_W-1, y=0, y=MAP_H-1) are ignored. This keeps the outer wall and tunnels intact; interior writes behave normally.
- Undefined: every in-range tile is writable, including the boundary.

Test Plan:
- Reset pulse, then lookups of (0,0), (5,0), (0,11), (26,11), (13,0), (13,23), (2,2), (3,3), (24,20), (1,1) -> q = 1,1,0,0,0,0,1,0,1,0.
- Lookups of (27,5), (255,5), (5,24), (5,127) -> q=1 for each.
- wr_en=1, (3,3), data 1 on a clk edge -> q for (3,3) goes 0 -> 1 after the edge; (2,2) and (4,4) are unchanged.
- wr_en=1, (2,2), data 0 -> q=0. Assert reset asynchronously between clock edges -> q for (2,2) returns to 1 before the next edge.
- Write with wr_x=30, or with reset held high -> map unchanged; full 27x24 sweep matches the default pattern, 214 walls.
- Write (0,5), data 0:
  - With MAP_WRITE_PROTECT_EN -> q stays 1.
  - Without it -> q becomes 0.
